// File: rtl/ultrassom_tri_medidor.sv
// ultrassom_tri_medidor: fires three HC-SR04 sensors in turn and reports each echo width as BCD centimetres.
// Define ULTRASSOM_ARREDONDA_EN to round half-up instead of truncating.
module ultrassom_tri_medidor #(
    parameter int TRIG_CYCLES    = 500,
    parameter int CM_CYCLES      = 2941,
    parameter int TIMEOUT_CYCLES = 1_500_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo1,
    input  logic        echo2,
    input  logic        echo3,
    output logic        trigger1,
    output logic        trigger2,
    output logic        trigger3,
    output logic [11:0] medida1,
    output logic [11:0] medida2,
    output logic [11:0] medida3,
    output logic [2:0]  erro,
    output logic        ocupado,
    output logic        pronto,
    output logic [3:0]  db_estado
);
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] TRIG    = 4'd1;
    localparam logic [3:0] WAIT    = 4'd2;
    localparam logic [3:0] COUNT   = 4'd3;
    localparam logic [3:0] TIMEOUT = 4'd4;
    localparam logic [3:0] STORE   = 4'd5;
    localparam logic [3:0] DONE    = 4'd6;
    localparam int TW = $clog2(TIMEOUT_CYCLES + TRIG_CYCLES + 1);
    localparam int SW = $clog2(CM_CYCLES + 1);
`ifdef ULTRASSOM_ARREDONDA_EN
    localparam logic [SW-1:0] SUB_INI = SW'(CM_CYCLES / 2);
`else
    localparam logic [SW-1:0] SUB_INI = '0;
`endif

    logic [3:0]    estado;
    logic [1:0]    idx;
    logic [TW-1:0] tmr;
    logic [SW-1:0] sub, sub_nx;
    logic [11:0]   bcd, bcd_nx;
    logic [2:0]    s1, s2, s3;
    logic          ech, rise, wrap;

    function automatic logic [11:0] inc_bcd(input logic [11:0] b);
        return b == 12'h999 ? b :
               b[3:0] != 4'd9 ? b + 12'd1 :
               b[7:4] != 4'd9 ? {b[11:8], b[7:4] + 4'd1, 4'h0} :
               {b[11:8] + 4'd1, 8'h00};
    endfunction

    // s3 holds the previous synchronized sample so an echo already high on entry is not a rise
    always_comb begin
        ech    = s2[idx];
        rise   = ech & ~s3[idx];
        wrap   = sub == SW'(CM_CYCLES - 1);
        sub_nx = wrap ? '0 : sub + 1'b1;
        bcd_nx = wrap ? inc_bcd(bcd) : bcd;
    end

    assign trigger1  = estado == TRIG && idx == 2'd0;
    assign trigger2  = estado == TRIG && idx == 2'd1;
    assign trigger3  = estado == TRIG && idx == 2'd2;
    assign ocupado   = estado != IDLE;
    assign pronto    = estado == DONE;
    assign db_estado = estado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            estado  <= IDLE;
            idx     <= '0;
            tmr     <= '0;
            sub     <= '0;
            bcd     <= '0;
            medida1 <= '0;
            medida2 <= '0;
            medida3 <= '0;
            erro    <= '0;
        end else begin
            s1  <= {echo3, echo2, echo1};
            s2  <= s1;
            s3  <= s2;
            tmr <= tmr + 1'b1;
            case (estado)
                IDLE: if (medir) begin
                    estado  <= TRIG;
                    idx     <= '0;
                    bcd     <= '0;
                    sub     <= SUB_INI;
                    erro[0] <= 1'b0;
                    tmr     <= '0;
                end
                TRIG: if (tmr == TW'(TRIG_CYCLES - 1)) begin
                    estado <= WAIT;
                    tmr    <= '0;
                end
                WAIT: if (rise) begin
                    estado <= COUNT;
                    tmr    <= '0;
                    sub    <= sub_nx;
                    bcd    <= bcd_nx;
                end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                    estado <= TIMEOUT;
                end
                COUNT: if (!ech) begin
                    estado <= STORE;
                end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
                    estado <= TIMEOUT;
                end else begin
                    sub <= sub_nx;
                    bcd <= bcd_nx;
                end
                TIMEOUT: begin
                    bcd       <= 12'h999;
                    erro[idx] <= 1'b1;
                    estado    <= STORE;
                end
                STORE: begin
                    if (idx == 2'd0) medida1 <= bcd;
                    if (idx == 2'd1) medida2 <= bcd;
                    if (idx == 2'd2) medida3 <= bcd;
                    if (idx == 2'd2) begin
                        estado <= DONE;
                    end else begin
                        estado            <= TRIG;
                        idx               <= idx + 2'd1;
                        bcd               <= '0;
                        sub               <= SUB_INI;
                        erro[idx + 2'd1]  <= 1'b0;
                        tmr               <= '0;
                    end
                end
                DONE:    estado <= IDLE;
                default: estado <= IDLE;
            endcase
        end
    end
endmodule
